// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Framing errors and full-FIFO drops are reported as one-cycle pulses.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int DIVW  = 20
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            rx,
   input  logic [DIVW-1:0] bitDiv,
   output logic [7:0]      rdData,
   output logic            rdValid,
   input  logic            rdReady,
   output logic            rxError,
   output logic            overflow,
   output logic            busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [DIVW-1:0] ONE = 1;
   localparam logic [AW:0] PONE = 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic            rx_meta;
   logic            rx_sync;
   logic            rx_prev;
   logic [DIVW-1:0] cnt;
   logic [DIVW-1:0] div_q;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic [7:0]      mem [DEPTH];
   logic [AW:0]     wptr;
   logic [AW:0]     rptr;
   logic            expire;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;
   logic            wr_en;

   assign expire  = (cnt == '0);
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop     = !empty && rdReady;
   assign push    = (state == STOP) && expire && rx_sync;
   // a pop in the same cycle frees the slot being written
   assign wr_en   = push && (!full || pop);
   assign rdValid = !empty;
   assign rdData  = empty ? 8'h00 : mem[rptr[AW-1:0]];
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         cnt      <= '0;
         div_q    <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rxError  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rx_meta  <= rx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rxError  <= 1'b0;
         overflow <= push && full && !pop;
         if (!expire)
            cnt <= cnt - ONE;
         unique case (state)
            IDLE: begin
               if (rx_prev && !rx_sync) begin
                  state <= START;
                  cnt   <= bitDiv >> 1;
                  div_q <= bitDiv;
               end
            end
            START: begin
               if (expire) begin
                  if (!rx_sync) begin
                     state   <= DATA;
                     cnt     <= div_q - ONE;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (expire) begin
                  shreg   <= {rx_sync, shreg[7:1]};
                  cnt     <= div_q - ONE;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end
            end
            STOP: begin
               if (expire) begin
                  rxError <= !rx_sync;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wptr[AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en)
            wptr <= wptr + PONE;
         if (pop)
            rptr <= rptr + PONE;
      end
   end
endmodule
